result_monitor: RTL
===================

# result_monitor

Receive-side companion to the operand driver in the adder simulation bench. The driver streams 8-bit A/B operand pairs into `MyTopLevel`; this block samples the DUT result (`io_X`) at the matching cycle, accounting for the DUT's pipeline latency. It packs up to `NUM_TXN` results LSB-first into a flat vector that the testbench reads back in one access. It is a synthesizable sequential block with an explicit capture FSM, not a testbench-only construct.

## Interface
Parameters:
- `DATA_W`, 8, result width (matches `io_X`)
- `NUM_TXN`, 200, results per capture burst
- `LATENCY`, 1, cycles from driver issuing an operand pair to the valid result on `res_i`; legal range 0..4
- `BUF_W`, `DATA_W*NUM_TXN` (1600), packed result vector width (derived; not overridden)

Ports:
- `clk_i`  in  1  clock; all logic on posedge
- `reset_ni`  in  1  synchronous, active-low reset
- `start_i`  in  1  arm a capture burst (single-cycle pulse)
- `clear_i`  in  1  acknowledge a finished burst and return to idle
- `valid_i`  in  1  driver issued an operand pair this cycle
- `res_i`  in  DATA_W  DUT result (`io_X`)
- `data_o`  out  BUF_W  packed results; slot k = bits [k*DATA_W +: DATA_W]
- `count_o`  out  8  results captured in the current burst (`$clog2(NUM_TXN+1)` bits)
- `busy_o`  out  1  state is CAPTURE
- `done_o`  out  1  state is DONE
- `overflow_o`  out  1  sticky; a sample arrived while in DONE

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - `start_i` = 1 → CAPTURE; `data_o` and `count_o` zeroed.
  - Delayed valids are ignored.
- CAPTURE:
  - When the delayed valid (`valid_i` delayed by `LATENCY` cycles) is 1, write `res_i` to slot `count_o`, then increment `count_o`.
  - When the write fills slot `NUM_TXN-1` → DONE.
  - `start_i` and `clear_i` are ignored.
- DONE:
  - `data_o` is frozen.
  - A delayed valid sets `overflow_o`; data and count are unchanged.
  - `clear_i` = 1 → IDLE; clears `done_o` and `overflow_o`. `data_o` and `count_o` are retained until the next `start_i`.
  - `start_i` is ignored.
- Delay line: runs in every state. With `LATENCY` = 0, `valid_i` qualifies `res_i` on the same edge.
- Packing order is LSB-first, mirroring the driver's consumption order (first result in `data_o[7:0]`).
- Reset (`reset_ni` = 0 at an edge), from any state including mid-capture:
  - state → IDLE
  - delay line, `data_o`, `count_o`, `done_o`, `overflow_o`, `busy_o` all → 0

## Timing
- Reset values: all outputs 0; state IDLE.
- `start_i` sampled at edge t: `busy_o` = 1 after t.
  - A delayed valid at edge t is not captured.
  - The first capturable sample is at edge t+1.
- A `valid_i` high at edge t lands `res_i` sampled at edge t+`LATENCY` into `data_o`, visible after that edge.
- The `NUM_TXN`-th capture edge also sets `done_o` = 1 and `busy_o` = 0. A sample on the next edge sets `overflow_o`.
- `clear_i` and a delayed valid on the same edge in DONE:
  - `overflow_o` ends at 0, because clear wins.
  - The state goes to IDLE and the sample is dropped.
- Back-to-back valids are captured every cycle; there is no throughput limit.

## Structure
- Package `bfm_pkg` holds:
  - the `mon_state_t` enum (IDLE/CAPTURE/DONE)
  - default constants `BFM_DATA_W` = 8 and `BFM_NUM_TXN` = 200, shared with the driver
- Sub-module `valid_delay`: a `LATENCY`-deep shift register on `valid_i`, with a pass-through when `LATENCY` = 0. It is reset by `reset_ni`.
- The top holds the FSM, the counter and the indexed slot write.

## Test plan
- Reset with `NUM_TXN`=4, `LATENCY`=1: hold `reset_ni`=0 for 3 cycles → all outputs 0, state IDLE. Pulse `valid_i` in IDLE → `count_o` stays 0.
- `start_i`, then 4 consecutive `valid_i` with `res_i` = 0x11, 0x22, 0x33, 0x44 one cycle later → `data_o[31:0]` = 0x44332211. `done_o` rises on the 4th capture edge; `busy_o` = 0.
- Same burst with `LATENCY`=3 and gapped valids (valid, idle, valid, valid, idle, valid) → the correct 4 values land in order. `count_o` steps 1..4 exactly on the delayed-valid edges.
- In DONE, one extra delayed valid with `res_i` = 0xFF → `overflow_o` = 1 and `data_o` unchanged. `clear_i` → IDLE, `overflow_o` = 0, `data_o` retained.
- Deassert `reset_ni` after 2 of 4 captures → everything zero, IDLE. A new `start_i` and burst captures cleanly from slot 0.
- Default parameters: 200 results, each equal to (A+B) mod 256 from the driver's stream → `data_o` bit-exact against the expected packing. `done_o` after the 200th; `count_o` = 200.

Source files
------------

// File: rtl/bfm_pkg.sv
// Shared types and default sizes for the adder-bench driver and result monitor.
package bfm_pkg;

  localparam int BFM_DATA_W  = 8;
  localparam int BFM_NUM_TXN = 200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } mon_state_t;

endpackage

// File: rtl/valid_delay.sv
// Aligns the driver's operand-valid strobe with the DUT result by delaying it
// LATENCY cycles; LATENCY = 0 is a straight wire.
module valid_delay #(
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic valid_i,
  output logic valid_o
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ reset_ni;
      assign valid_o        = valid_i;
    end else begin : g_shift
      logic [LATENCY-1:0] pipe_q;
      logic [LATENCY-1:0] pipe_d;

      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = valid_i;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign valid_o = pipe_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/result_monitor.sv
// Captures a burst of NUM_TXN DUT results, LSB-first, into one flat vector.
// state   | meaning
// IDLE    | waiting for start_i; previous burst's data/count retained
// CAPTURE | writing each delayed-valid result into slot count_o
// DONE    | burst full, data frozen; extra samples raise overflow_o
module result_monitor
  import bfm_pkg::*;
#(
  parameter  int DATA_W  = BFM_DATA_W,
  parameter  int NUM_TXN = BFM_NUM_TXN,
  parameter  int LATENCY = 1,
  parameter  int BUF_W   = DATA_W * NUM_TXN,
  localparam int CNT_W   = $clog2(NUM_TXN + 1)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] res_i,
  output logic [BUF_W-1:0]  data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  mon_state_t        state_q, state_d;
  logic [BUF_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              valid_dly;

  valid_delay #(
    .LATENCY (LATENCY)
  ) u_valid_delay (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .valid_o  (valid_dly)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CAPTURE;
          data_d  = '0;
          count_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (valid_dly) begin
          // Decoded slot write keeps the index arithmetic out of the datapath.
          for (int k = 0; k < NUM_TXN; k++) begin
            if (int'(count_q) == k) begin
              data_d[k*DATA_W +: DATA_W] = res_i;
            end
          end
          count_d = count_q + CNT_W'(1);
          if (int'(count_q) == NUM_TXN - 1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Clear takes priority so an acknowledged burst never reports overflow.
        if (clear_i) begin
          state_d    = ST_IDLE;
          overflow_d = 1'b0;
        end else if (valid_dly) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign count_o    = count_q;
  assign busy_o     = (state_q == ST_CAPTURE);
  assign done_o     = (state_q == ST_DONE);
  assign overflow_o = overflow_q;

endmodule
